// File: rtl/wb_seq_pkg.sv
// Shared constants for the Wishbone host sequencer: state encoding, address alignment and byte-select sizing.
package wb_seq_pkg;

    localparam int          ALIGN_BITS       = 2;
    localparam logic [31:0] WB_SEQ_BASE_ADDR = 32'h3000_0000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic int sel_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/wb_seq_watchdog.sv
// Bus-cycle watchdog: counts cycles while enabled and flags the last permitted cycle before abort.
module wb_seq_watchdog #(
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: i_clear includes reset, so the count needs no reset branch of its own.
    always_ff @(posedge clk) begin
        if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_host_sequencer.sv
// Wishbone classic single-beat initiator driven by a valid/ready command stream, one response per command.
// Define WB_SEQ_TIMEOUT_EN to enable the ack watchdog; otherwise BUS waits for ack indefinitely.
module wb_host_sequencer
    import wb_seq_pkg::*;
#(
    parameter int  ADDR_W         = 32,
    parameter int  DATA_W         = 32,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int SEL_W          = sel_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i,
    output logic              busy
);

    logic [1:0]        r_state;
    logic              r_cyc;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdat;
    logic [DATA_W-1:0] r_rdata;
    logic              w_unused;

`ifdef WB_SEQ_TIMEOUT_EN
    logic r_err;
    logic w_expired;

    wb_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .i_clear  (rst || (r_state != ST_BUS)),
        .i_enable (r_state == ST_BUS),
        .o_expired(w_expired)
    );

    assign rsp_err  = r_err;
    assign w_unused = ^cmd_addr[ALIGN_BITS-1:0];
`else
    assign rsp_err  = 1'b0;
    assign w_unused = ^{cmd_addr[ALIGN_BITS-1:0], (TIMEOUT_CYCLES >= 2)};
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdata <= '0;
`ifdef WB_SEQ_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_we    <= cmd_we;
                        r_sel   <= cmd_sel;
                        r_wdat  <= cmd_wdata;
                        r_adr   <= {cmd_addr[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
                        r_cyc   <= 1'b1;
                        r_state <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // Ack takes priority, including on the final watchdog cycle.
                    if (wbm_ack_i) begin
                        r_rdata <= r_we ? '0 : wbm_dat_i;
                        r_cyc   <= 1'b0;
                        r_state <= ST_RESP;
`ifdef WB_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
                    end else if (w_expired) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_state <= ST_RESP;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE) && !rst;
    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_rdata = r_rdata;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_wdat;

endmodule

// File: tb/tb_wb_host_sequencer.sv
// Self-checking bench for wb_host_sequencer: register-slave responder, scoreboard model and per-cycle compare.
// Exercises the watchdog path when WB_SEQ_TIMEOUT_EN is defined, the indefinite-wait path otherwise.
module tb_wb_host_sequencer;

    localparam int TO = 16;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, busy;

    logic        slave_ack, stray_ack;
    bit          slave_ack_en;
    int          slave_delay;
    logic [31:0] slave_mem [8];
    logic [31:0] model_mem [8];
    txn_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign wbm_ack_i = slave_ack | stray_ack;

    always #5 clk = ~clk;

    wb_host_sequencer #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Expected transaction; a completed write updates the model register file.
    function automatic txn_t make_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] sel, input bit will_ack);
        txn_t t;
        int   idx = int'(addr[4:2]);
        t.we    = we;
        t.adr   = {addr[31:2], 2'b00};
        t.wdata = wdata;
        t.sel   = sel;
        if (will_ack) begin
            t.err   = 1'b0;
            t.rdata = we ? 32'h0 : model_mem[idx];
            if (we) model_mem[idx] = merge(model_mem[idx], wdata, sel);
        end else begin
            t.err   = 1'b1;
            t.rdata = 32'h0;
        end
        return t;
    endfunction

    // Register slave: acks slave_delay cycles after seeing stb, returns junk data when not acking.
    initial begin
        int wcnt = 0;
        int idx;
        slave_ack = 1'b0;
        wbm_dat_i = 32'hA5A5_5A5A;
        forever begin
            @(posedge clk);
            #1;
            if (wbm_cyc_o && wbm_stb_o && slave_ack_en && !slave_ack) begin
                if (wcnt >= slave_delay) begin
                    idx       = int'(wbm_adr_o[4:2]);
                    slave_ack = 1'b1;
                    wbm_dat_i = slave_mem[idx];
                    if (wbm_we_o) slave_mem[idx] = merge(slave_mem[idx], wbm_dat_o, wbm_sel_o);
                end else begin
                    wcnt++;
                end
            end else begin
                slave_ack = 1'b0;
                wbm_dat_i = 32'hA5A5_5A5A;
                wcnt      = 0;
            end
        end
    end

    // Per-cycle compare of bus and response outputs against the scoreboard head.
    initial begin
        txn_t h;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_iff_idle", {31'b0, cmd_ready}, {31'b0, !busy});
                if (wbm_cyc_o) begin
                    check("bus_has_txn", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        h = exp_q[0];
                        check("bus_stb", {31'b0, wbm_stb_o}, 1);
                        check("bus_we", {31'b0, wbm_we_o}, {31'b0, h.we});
                        check("bus_adr", wbm_adr_o, h.adr);
                        check("bus_sel", {28'b0, wbm_sel_o}, {28'b0, h.sel});
                        check("bus_dat", wbm_dat_o, h.wdata);
                    end
                end
                if (rsp_valid) begin
                    check("rsp_cyc_low", {31'b0, wbm_cyc_o}, 0);
                    check("rsp_has_txn", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        h = exp_q[0];
                        check("rsp_rdata", rsp_rdata, h.rdata);
                        check("rsp_err", {31'b0, rsp_err}, {31'b0, h.err});
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, input bit will_ack);
        txn_t t = make_txn(we, addr, wdata, sel, will_ack);
        bit   done = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        for (int i = 0; i < 50 && !done; i++) begin
            if (cmd_ready) begin
                exp_q.push_back(t);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", {31'b0, done}, 1);
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic er, input int max_cycles);
        bit seen = 0;
        rd = 32'hX;
        er = 1'bX;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (rsp_valid && rsp_ready) begin
                rd   = rsp_rdata;
                er   = rsp_err;
                seen = 1;
                check("cyc_low_after_ack", {31'b0, wbm_cyc_o}, 0);
            end
            @(posedge clk);
            #1;
        end
        check("rsp_seen", {31'b0, seen}, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd0;
        logic        er, er0;
        int          n;
        txn_t        tb;

        rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_sel = 0;
        rsp_ready = 1'b1; stray_ack = 1'b0; slave_ack_en = 1'b1; slave_delay = 0;
        for (int i = 0; i < 8; i++) begin
            slave_mem[i] = 32'h0;
            model_mem[i] = 32'h0;
        end

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_cyc", {31'b0, wbm_cyc_o}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        #1;
        check("idle_cmd_ready", {31'b0, cmd_ready}, 1);

        // 1: write, stb the cycle after accept
        send(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 1);
        check("t1_stb", {31'b0, wbm_stb_o}, 1);
        check("t1_we", {31'b0, wbm_we_o}, 1);
        check("t1_adr", wbm_adr_o, 32'h3000_0000);
        check("t1_dat", wbm_dat_o, 32'hDEAD_BEEF);
        wait_rsp(rd, er, 20);
        check("t1_rdata", rd, 32'h0);
        check("t1_err", {31'b0, er}, 0);

        // 2: readback and unaligned address
        send(1'b0, 32'h3000_0000, 32'h0, 4'hF, 1);
        wait_rsp(rd, er, 20);
        check("t2_rdata", rd, 32'hDEAD_BEEF);
        check("t2_err", {31'b0, er}, 0);
        send(1'b0, 32'h3000_0013, 32'h0, 4'hF, 1);
        check("t2_unaligned_adr", wbm_adr_o, 32'h3000_0010);
        wait_rsp(rd, er, 20);

        // 3: partial write merges one byte, read with a slow slave
        send(1'b1, 32'h3000_0004, 32'h1122_3344, 4'hF, 1);
        wait_rsp(rd, er, 20);
        send(1'b1, 32'h3000_0004, 32'h0000_00AA, 4'h1, 1);
        wait_rsp(rd, er, 20);
        slave_delay = 2;
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1);
        wait_rsp(rd, er, 20);
        check("t3_partial", rd, 32'h1122_33AA);
        slave_delay = 0;

        // 4: no ack
        slave_ack_en = 1'b0;
`ifdef WB_SEQ_TIMEOUT_EN
        send(1'b1, 32'h3000_0008, 32'h0000_0055, 4'hF, 0);
        n = 0;
        while (wbm_cyc_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("t4_stb_cycles", n, TO);
        wait_rsp(rd, er, 5);
        check("t4_err", {31'b0, er}, 1);
        check("t4_rdata", rd, 32'h0);
        slave_ack_en = 1'b1;
        send(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1);
        wait_rsp(rd, er, 20);
        check("t4_no_write", rd, 32'h0);
`else
        send(1'b1, 32'h3000_0008, 32'h0000_0055, 4'hF, 1);
        repeat (1000) begin @(posedge clk); #1; end
        check("t4_still_cyc", {31'b0, wbm_cyc_o}, 1);
        check("t4_no_rsp", {31'b0, rsp_valid}, 0);
        slave_ack_en = 1'b1;
        wait_rsp(rd, er, 20);
        check("t4_err", {31'b0, er}, 0);
        check("t4_rdata", rd, 32'h0);
        n = 0;
`endif

        // 5: response back-pressure with a second command waiting
        rsp_ready = 1'b0;
        send(1'b1, 32'h3000_000C, 32'h0BAD_F00D, 4'hC, 1);
        n = 0;
        while (!rsp_valid && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        rd0 = rsp_rdata;
        er0 = rsp_err;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h3000_000C; cmd_wdata = 32'h0; cmd_sel = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check("t5_rsp_held", {31'b0, rsp_valid}, 1);
            check("t5_rdata_held", rsp_rdata, rd0);
            check("t5_err_held", {31'b0, rsp_err}, {31'b0, er0});
            check("t5_cmd_blocked", {31'b0, cmd_ready}, 0);
            check("t5_no_cyc", {31'b0, wbm_cyc_o}, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_ready_after_hs", {31'b0, cmd_ready}, 1);
        tb = make_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1);
        exp_q.push_back(tb);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t5_second_accepted", {31'b0, wbm_cyc_o}, 1);
        wait_rsp(rd, er, 20);
        check("t5_second_rdata", rd, 32'h0BAD_0000);

        // 6: reset mid-BUS, then a stray ack in IDLE
        slave_ack_en = 1'b0;
        send(1'b1, 32'h3000_0010, 32'h0000_0077, 4'hF, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_cyc", {31'b0, wbm_cyc_o}, 0);
        check("t6_stb", {31'b0, wbm_stb_o}, 0);
        check("t6_we", {31'b0, wbm_we_o}, 0);
        check("t6_sel", {28'b0, wbm_sel_o}, 0);
        check("t6_adr", wbm_adr_o, 0);
        check("t6_dat", wbm_dat_o, 0);
        check("t6_no_rsp", {31'b0, rsp_valid}, 0);
        check("t6_idle", {31'b0, busy}, 0);
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("t6_stray_busy", {31'b0, busy}, 0);
        check("t6_stray_rsp", {31'b0, rsp_valid}, 0);
        check("t6_stray_cyc", {31'b0, wbm_cyc_o}, 0);
        slave_ack_en = 1'b1;
        send(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1);
        wait_rsp(rd, er, 20);
        check("t6_not_written", rd, 32'h0);
        send(1'b0, 32'h3000_0004, 32'h0, 4'hF, 1);
        wait_rsp(rd, er, 20);
        check("t6_state_intact", rd, 32'h1122_33AA);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
